// File: rtl/mem_resp_ctrl.sv
// Memory-side responder for the sys req/wr/rdy handshake. It owns an on-chip
// word array, applies a fixed latency per direction and pulses rdy once per
// completed request.
module mem_resp_ctrl #(
    parameter int unsigned AW     = 13,
    parameter int unsigned DW     = 64,
    parameter int unsigned RD_LAT = 3,
    parameter int unsigned WR_LAT = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   addr,
    input  logic [DW-1:0] dout,
    input  logic          req,
    input  logic          wr,
    output logic [DW-1:0] din,
    output logic          rdy,
    output logic          err,
    output logic [31:0]   rd_cnt,
    output logic [31:0]   wr_cnt,
    input  logic          init_we,
    input  logic [AW-1:0] init_addr,
    input  logic [DW-1:0] init_data
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 4;
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          oor_q, oor_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] din_q, din_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;
    logic [31:0]   rd_cnt_q, rd_cnt_d;
    logic [31:0]   wr_cnt_q, wr_cnt_d;
    logic          init_c;
    logic          done_c;
    logic          commit_c;

    logic [DW-1:0] mem_q [DEPTH];

    // Request sequencing: accept in IDLE, count down in WAIT, one dead cycle in GAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        oor_d   = oor_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        init_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = wr ? WR_LOAD : RD_LOAD;
                    addr_d  = addr[AW-1:0];
                    oor_d   = |addr[63:AW];
                    wr_d    = wr;
                    wdata_d = dout;
                end else if (init_we && rst) begin
                    init_c = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Completion: rdy, read data, error flag and counters all load on the edge that starts the rdy cycle.
    always_comb begin
        done_c   = (state_d == WAIT) && (cnt_d == '0);
        rdy_d    = done_c;
        din_d    = din_q;
        err_d    = err_q | (done_c & oor_d);
        rd_cnt_d = rd_cnt_q + 32'(done_c & ~wr_d);
        wr_cnt_d = wr_cnt_q + 32'(done_c & wr_d);
        if (done_c && !wr_d) begin
            din_d = oor_d ? '0 : mem_q[addr_d];
        end
        commit_c = rdy_q & wr_q & ~oor_q;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            oor_q    <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            din_q    <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            oor_q    <= oor_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            din_q    <= din_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Word array: write commit at the end of the rdy cycle, else preload; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem_q[addr_q] <= wdata_q;
        end else if (init_c) begin
            mem_q[init_addr] <= init_data;
        end
    end

    assign din    = din_q;
    assign rdy    = rdy_q;
    assign err    = err_q;
    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed plus randomized bench for mem_resp_ctrl with a word-level memory model.
module tb_mem_resp_ctrl;

    localparam int unsigned AW     = 13;
    localparam int unsigned DW     = 64;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned WR_LAT = 6;
    localparam int unsigned NPOOL  = 32;
    localparam int unsigned NSOAK  = 250;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   addr;
    logic [DW-1:0] dout;
    logic          req;
    logic          wr;
    logic [DW-1:0] din;
    logic          rdy;
    logic          err;
    logic [31:0]   rd_cnt;
    logic [31:0]   wr_cnt;
    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [DW-1:0] init_data;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;
    int cyc   = 0;
    logic rdy_prev = 1'b0;

    logic [63:0] model [int];
    int exp_rd = 0;
    int exp_wr = 0;

    mem_resp_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .rst(rst), .addr(addr), .dout(dout), .req(req), .wr(wr),
        .din(din), .rdy(rdy), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watch for rdy high in two consecutive cycles.
    always @(negedge clk) begin
        if (rdy && rdy_prev) viol <= viol + 1;
        rdy_prev <= rdy;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [63:0] d);
        @(negedge clk);
        init_we = 1'b1; init_addr = a; init_data = d;
        @(negedge clk);
        init_we = 1'b0;
        model[int'(a)] = d;
    endtask

    // One request from IDLE; returns measured latency (-1 on timeout) and din in the rdy cycle.
    // With iw set, a conflicting preload is presented in the accept cycle and must lose.
    task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic iw, output int lat, output logic [63:0] rdata);
        int j;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; dout = d;
        if (iw) begin
            init_we = 1'b1; init_addr = a[AW-1:0]; init_data = ~d;
        end
        @(posedge clk); #1;
        req = 1'b0; init_we = 1'b0;
        wr = 1'($urandom()); addr = {$urandom(), $urandom()}; dout = {$urandom(), $urandom()};
        j = 0;
        while (!rdy && j < 20) begin
            @(posedge clk); #1;
            j++;
        end
        lat   = rdy ? j + 1 : -1;
        rdata = din;
        if (w) exp_wr++; else exp_rd++;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_rd = 0; exp_wr = 0;
    endtask

    initial begin
        int lat;
        int t0, t1, t2, j;
        logic [63:0] rd, prev;
        logic seen;
        logic [AW-1:0] pool [NPOOL];

        void'($urandom(32'd20240611));

        // Reset with random inputs
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            req = 1'($urandom()); wr = 1'($urandom());
            addr = {$urandom(), $urandom()}; dout = {$urandom(), $urandom()};
            init_we = 1'($urandom()); init_addr = AW'($urandom()); init_data = {$urandom(), $urandom()};
        end
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_din", din, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        req = 1'b0; init_we = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Read latency and data
        preload(AW'(5), 64'hDEAD_BEEF_0123_4567);
        xact(1'b0, 64'd5, 64'd0, 1'b0, lat, rd);
        chk("rd_lat", 64'(lat), 64'(RD_LAT));
        chk("rd_data", rd, 64'hDEAD_BEEF_0123_4567);
        chk("rd_cnt_1", 64'(rd_cnt), 64'd1);

        // Write 0x1FFF with req held through GAP; held req becomes a read of 0x1FFF
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 64'h1FFF; dout = 64'h1;
        @(posedge clk); #1;
        t0 = cyc;
        wr = 1'b0; dout = {$urandom(), $urandom()};
        j = 0;
        while (!rdy && j < 20) begin @(posedge clk); #1; j++; end
        t1 = rdy ? cyc : -1000;
        chk("wr_lat", 64'(t1 - t0 + 1), 64'(WR_LAT));
        @(posedge clk); #1;
        j = 0;
        while (!rdy && j < 20) begin @(posedge clk); #1; j++; end
        t2 = rdy ? cyc : -1000;
        req = 1'b0;
        chk("b2b_rdy_spacing", 64'(t2 - t0), 64'(WR_LAT + 2 + RD_LAT - 1));
        chk("raw_data", din, 64'h1);
        @(posedge clk); @(posedge clk); #1;
        exp_wr++; exp_rd++;
        model[13'h1FFF] = 64'h1;
        chk("wr_cnt_1", 64'(wr_cnt), 64'd1);
        chk("rd_cnt_2", 64'(rd_cnt), 64'd2);

        // req beats a simultaneous preload to the same word
        preload(AW'(13'h0100), 64'hA5A5_0000_1111_2222);
        xact(1'b0, 64'h100, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, lat, rd);
        chk("prio_rd", rd, 64'hA5A5_0000_1111_2222);
        xact(1'b0, 64'h100, 64'd0, 1'b0, lat, rd);
        chk("prio_kept", rd, 64'hA5A5_0000_1111_2222);

        // Out of range; reset first so counts start at zero and array must persist
        preload(AW'(0), 64'hC0FF_EE00_1234_5678);
        do_reset();
        chk("oor_err_pre", 64'(err), 64'd0);
        xact(1'b1, 64'h2000, 64'h7777_7777_7777_7777, 1'b0, lat, rd);
        chk("oor_wr_lat", 64'(lat), 64'(WR_LAT));
        xact(1'b0, 64'h2000, 64'd0, 1'b0, lat, rd);
        chk("oor_rd_lat", 64'(lat), 64'(RD_LAT));
        chk("oor_rd_data", rd, 64'd0);
        chk("oor_err", 64'(err), 64'd1);
        chk("oor_wr_cnt", 64'(wr_cnt), 64'd1);
        chk("oor_rd_cnt", 64'(rd_cnt), 64'd1);
        xact(1'b0, 64'h0, 64'd0, 1'b0, lat, rd);
        chk("oor_arr0_kept", rd, 64'hC0FF_EE00_1234_5678);
        xact(1'b0, 64'h8000_0000_0000_0005, 64'd0, 1'b0, lat, rd);
        chk("oor_hi_rd_data", rd, 64'd0);
        chk("oor_err_sticky", 64'(err), 64'd1);

        // Reset two cycles into a write
        preload(AW'(3), 64'h55);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 64'h3; dout = 64'hAA;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy", 64'(rdy), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_rd_cnt", 64'(rd_cnt), 64'd0);
        chk("mid_rst_wr_cnt", 64'(wr_cnt), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_rd = 0; exp_wr = 0;
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (rdy) seen = 1'b1; end
        chk("mid_rst_no_rdy", 64'(seen), 64'd0);
        xact(1'b0, 64'h3, 64'd0, 1'b0, lat, rd);
        chk("mid_rst_arr3", rd, 64'h55);

        // Random read-increment-write soak over a seeded address pool
        pool[0] = AW'(13'h1FFF);
        for (int i = 1; i < int'(NPOOL); i++) pool[i] = AW'($urandom_range(0, 32'h1FFF));
        for (int i = 0; i < int'(NPOOL); i++) preload(pool[i], {$urandom(), $urandom()});
        for (int n = 0; n < int'(NSOAK); n++) begin
            logic [AW-1:0] a;
            a = pool[$urandom_range(0, NPOOL - 1)];
            xact(1'b0, 64'(a), {$urandom(), $urandom()}, 1'b0, lat, rd);
            chk("soak_rd_lat", 64'(lat), 64'(RD_LAT));
            chk("soak_rd_data", rd, model[int'(a)]);
            prev = rd;
            xact(1'b1, 64'(a), model[int'(a)] + 64'd1, 1'b0, lat, rd);
            chk("soak_wr_lat", 64'(lat), 64'(WR_LAT));
            chk("soak_din_held", rd, prev);
            model[int'(a)] = model[int'(a)] + 64'd1;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        for (int i = 0; i < int'(NPOOL); i++) begin
            xact(1'b0, 64'(pool[i]), 64'd0, 1'b0, lat, rd);
            chk("soak_final_word", rd, model[int'(pool[i])]);
        end
        chk("soak_rd_cnt", 64'(rd_cnt), 64'(exp_rd));
        chk("soak_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
        chk("soak_err", 64'(err), 64'd0);
        @(negedge clk);
        chk("rdy_never_consecutive", 64'(viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
